// File: rtl/ioctl_pkg.sv
// ioctl_pkg: shared FSM encoding, address width and file indices for the ioctl download path
package ioctl_pkg;
    localparam int IOCTL_ADDR_W = 25;
    localparam logic [7:0] IOCTL_IDX_ROM = 8'd0;
    localparam logic [7:0] IOCTL_IDX_TAPE = 8'd1;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_FETCH,
        ST_WRITE,
        ST_GAP,
        ST_TAIL
    } ioctl_state_e;
endpackage

// File: rtl/ioctl_delay_cnt.sv
// ioctl_delay_cnt: loadable down-counter with hold, reporting when it has reached zero
module ioctl_delay_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         hold_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else if (load_i) cnt_q <= val_i;
        else if (!hold_i && cnt_q != '0) cnt_q <= cnt_q - W'(1);
    end
    assign zero_o = cnt_q == '0;
endmodule

// File: rtl/ioctl_download_tx.sv
// ioctl_download_tx: drives the core's ioctl download handshake from a byte stream with wait back-pressure
module ioctl_download_tx
    import ioctl_pkg::*;
#(
    parameter int ADDR_W    = IOCTL_ADDR_W,
    parameter int SETUP_CYC = 8,
    parameter int WR_GAP    = 4,
    parameter int TAIL_CYC  = 8
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        req_index,
    input  logic [ADDR_W-1:0] req_length,
    input  logic [7:0]        src_data,
    input  logic              src_valid,
    output logic              src_ready,
    output logic              ioctl_download,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout,
    output logic [7:0]        ioctl_index,
    input  logic              ioctl_wait,
    output logic              busy,
    output logic              done
);
    ioctl_state_e state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d, cnt_q, cnt_d, addr_q, addr_d;
    logic [7:0] dout_q, dout_d, index_q, index_d;
    logic wr_q, wr_d, active_q, active_d, done_q, done_d;
    logic dly_load, dly_hold, dly_zero;
    logic [7:0] dly_val;

    ioctl_delay_cnt #(.W(8)) u_dly (
        .clk    (clk_sys),
        .rst    (reset),
        .load_i (dly_load),
        .val_i  (dly_val),
        .hold_i (dly_hold),
        .zero_o (dly_zero)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        index_d = index_q;
        wr_d    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                index_d = req_index;
                len_d   = req_length;
                cnt_d   = '0;
                state_d = ST_SETUP;
            end
            ST_SETUP: if (abort) state_d = ST_TAIL;
                else if (dly_zero) state_d = len_q == '0 ? ST_TAIL : ST_FETCH;
            ST_FETCH: begin
                if (src_valid) begin
                    dout_d = src_data;
                    addr_d = cnt_q;
                end
                state_d = abort ? ST_TAIL : src_valid ? ST_WRITE : ST_FETCH;
            end
            ST_WRITE: if (abort) state_d = ST_TAIL;
                else if (!ioctl_wait) begin
                    wr_d    = 1'b1;
                    cnt_d   = cnt_q + ADDR_W'(1);
                    state_d = ST_GAP;
                end
            ST_GAP: if (abort) state_d = ST_TAIL;
                else if (dly_zero) state_d = cnt_q == len_q ? ST_TAIL : ST_FETCH;
            ST_TAIL: if (dly_zero) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        active_d = state_d != ST_IDLE;
        // SETUP/GAP reach zero after exactly N cycles; TAIL gets one extra cycle to close the window
        dly_load = state_d != state_q;
        dly_val  = state_d == ST_SETUP ? 8'(SETUP_CYC - 1) :
                   state_d == ST_GAP   ? 8'(WR_GAP - 1)    : 8'(TAIL_CYC);
        dly_hold = state_q == ST_GAP && ioctl_wait;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            dout_q   <= '0;
            index_q  <= '0;
            wr_q     <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            index_q  <= index_d;
            wr_q     <= wr_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign src_ready      = state_q == ST_FETCH;
    assign ioctl_download = active_q;
    assign busy           = active_q;
    assign ioctl_wr       = wr_q;
    assign ioctl_addr     = addr_q;
    assign ioctl_dout     = dout_q;
    assign ioctl_index    = index_q;
    assign done           = done_q;
endmodule

// File: tb/tb_ioctl_download_tx.sv
// tb_ioctl_download_tx: directed checks of strobe timing, back-pressure, stalls, abort and reset
module tb_ioctl_download_tx;
    logic clk_sys = 1'b0;
    logic reset = 1'b1, start = 1'b0, abort = 1'b0, ioctl_wait = 1'b0, src_valid = 1'b1;
    logic [7:0] req_index = '0, src_data;
    logic [24:0] req_length = '0;
    logic src_ready, ioctl_download, ioctl_wr, busy, done;
    logic [24:0] ioctl_addr;
    logic [7:0] ioctl_dout, ioctl_index;

    ioctl_download_tx dut (
        .clk_sys(clk_sys), .reset(reset), .start(start), .abort(abort),
        .req_index(req_index), .req_length(req_length),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
        .busy(busy), .done(done)
    );

    always #5 clk_sys = ~clk_sys;

    int n_chk = 0, n_fail = 0;
    int ec = 0, t0 = 0, acc = 0;
    int n_wr = 0, n_done = 0, done_rel = -1, dl_rise_rel = -1, dl_fall_rel = -1, idx_bad = 0;
    int wr_rel[16];
    logic [24:0] wr_addr[16];
    logic [7:0] wr_dout[16];
    logic [7:0] bytes[16];
    logic [7:0] exp_index = '0;
    logic prev_dl = 1'b0;

    assign src_data = bytes[acc[3:0]];

    always @(posedge clk_sys) begin
        if (start) acc <= 0;
        else if (src_valid && src_ready) acc <= acc + 1;
    end

    always @(posedge clk_sys) begin
        #1;
        ec++;
        if (ioctl_wr) begin
            if (n_wr < 16) begin
                wr_rel[n_wr] = ec - t0;
                wr_addr[n_wr] = ioctl_addr;
                wr_dout[n_wr] = ioctl_dout;
            end
            n_wr++;
        end
        if (done) begin
            n_done++;
            done_rel = ec - t0;
        end
        if (ioctl_download && !prev_dl && dl_rise_rel < 0) dl_rise_rel = ec - t0;
        if (!ioctl_download && prev_dl && dl_fall_rel < 0) dl_fall_rel = ec - t0;
        if (ioctl_download && ioctl_index !== exp_index) idx_bad++;
        prev_dl = ioctl_download;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_rel(input int k);
        while (ec - t0 < k) begin
            @(posedge clk_sys);
            #2;
        end
    endtask

    task automatic do_start(input logic [7:0] idx, input logic [24:0] len);
        n_wr = 0; n_done = 0; done_rel = -1; dl_rise_rel = -1; dl_fall_rel = -1; idx_bad = 0;
        exp_index = idx;
        req_index = idx;
        req_length = len;
        t0 = ec;
        start = 1'b1;
        @(posedge clk_sys);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i = 0;
        while (n_done == 0 && i < budget) begin
            @(posedge clk_sys);
            #2;
            i++;
        end
        if (n_done == 0) check({tag, "_timeout"}, 0, 1);
        repeat (3) begin
            @(posedge clk_sys);
            #2;
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_outs"}, {ioctl_download, ioctl_wr, busy, done, src_ready}, 0);
        check({tag, "_addr"}, 32'(ioctl_addr), 0);
        check({tag, "_dout_idx"}, {ioctl_dout, ioctl_index}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) bytes[i] = 8'(i * 17 + 3);
        repeat (3) @(posedge clk_sys);
        #2;
        check_idle_zero("reset");
        reset = 1'b0;
        @(posedge clk_sys);
        #2;

        // basic three-byte transfer
        bytes[0] = 8'hA1; bytes[1] = 8'hB2; bytes[2] = 8'hC3;
        do_start(8'h01, 25'd3);
        wait_done("basic", 100);
        check("basic_rise", dl_rise_rel, 1);
        check("basic_nwr", n_wr, 3);
        for (int i = 0; i < 3; i++) begin
            check("basic_wr_cyc", wr_rel[i], 11 + 6 * i);
            check("basic_addr", 32'(wr_addr[i]), i);
        end
        check("basic_dout", {wr_dout[0], wr_dout[1], wr_dout[2]}, 24'hA1B2C3);
        check("basic_done_cyc", done_rel, 36);
        check("basic_fall", dl_fall_rel, 36);
        check("basic_ndone", n_done, 1);
        check("basic_index", idx_bad, 0);
        check("basic_hold", {busy, ioctl_index, 7'(ioctl_addr)}, {1'b0, 8'h01, 7'd2});

        // zero-length request
        do_start(8'h00, 25'd0);
        wait_done("len0", 100);
        check("len0_nwr", n_wr, 0);
        check("len0_window", dl_fall_rel - dl_rise_rel, 17);
        check("len0_done", {n_done, done_rel}, {32'd1, 32'd18});

        // wait held for 20 cycles in WRITE
        bytes[0] = 8'h11; bytes[1] = 8'h22;
        do_start(8'h01, 25'd2);
        wait_rel(10);
        ioctl_wait = 1'b1;
        begin
            int bad = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk_sys);
                #2;
                if (ioctl_wr || ioctl_addr !== 25'd0 || ioctl_dout !== 8'h11) bad++;
            end
            check("wait_stable", bad, 0);
        end
        ioctl_wait = 1'b0;
        wait_done("wait", 100);
        check("wait_nwr", n_wr, 2);
        check("wait_wr0", {wr_rel[0], 24'(wr_addr[0]), wr_dout[0]}, {32'd31, 24'd0, 8'h11});
        check("wait_wr1", {wr_rel[1], 24'(wr_addr[1]), wr_dout[1]}, {32'd37, 24'd1, 8'h22});

        // source stall before byte 2
        bytes[0] = 8'h10; bytes[1] = 8'h20; bytes[2] = 8'h30;
        do_start(8'h01, 25'd3);
        wait_rel(12);
        src_valid = 1'b0;
        wait_rel(62);
        check("stall_dl_high", {ioctl_download, 31'(n_wr)}, {1'b1, 31'd1});
        src_valid = 1'b1;
        wait_done("stall", 150);
        check("stall_nwr", n_wr, 3);
        check("stall_addrs", {8'(wr_addr[0]), 8'(wr_addr[1]), 8'(wr_addr[2])}, 24'h000102);
        check("stall_dout", {wr_dout[0], wr_dout[1], wr_dout[2]}, 24'h102030);
        check("stall_wr1", wr_rel[1], 64);
        check("stall_fall", {dl_fall_rel, n_done}, {32'd83, 32'd1});

        // abort two cycles after the second strobe
        for (int i = 0; i < 16; i++) bytes[i] = 8'(i * 17 + 3);
        do_start(8'h00, 25'd10);
        wait_rel(19);
        abort = 1'b1;
        wait_rel(20);
        abort = 1'b0;
        wait_done("abort", 100);
        check("abort_nwr", n_wr, 2);
        check("abort_fall", dl_fall_rel, 29);
        check("abort_ndone", n_done, 1);
        bytes[0] = 8'h5A;
        do_start(8'h01, 25'd1);
        wait_done("after_abort", 100);
        check("after_abort_wr", {n_wr, wr_rel[0]}, {32'd1, 32'd11});
        check("after_abort_data", {8'(wr_addr[0]), wr_dout[0]}, 16'h005A);

        // reset in the middle of GAP
        do_start(8'h01, 25'd3);
        wait_rel(12);
        reset = 1'b1;
        wait_rel(13);
        check_idle_zero("rst_gap");
        reset = 1'b0;
        bytes[0] = 8'h55; bytes[1] = 8'h66;
        do_start(8'h01, 25'd2);
        wait_done("rst_restart", 100);
        check("rst_restart_nwr", n_wr, 2);
        check("rst_restart_cyc", {wr_rel[0], wr_rel[1]}, {32'd11, 32'd17});
        check("rst_restart_data", {8'(wr_addr[0]), wr_dout[0], 8'(wr_addr[1]), wr_dout[1]}, 32'h0055_0166);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ioctl_download_tx.md
Name: ioctl_download_tx

Overview:
- Initiator side of the core's ioctl download interface: turns a byte stream plus a (index, length) request into the ioctl_download / ioctl_wr / ioctl_addr / ioctl_dout / ioctl_index sequence that the lynx48 core consumes.
- Honours ioctl_wait back-pressure from the core.
- Used in the Verilator top level, replacing C++-side ioctl driving, and reusable as a boot/ROM/tape loader in hardware test builds.

Parameters:
- ADDR_W, 25, width of ioctl_addr and length.
- SETUP_CYC, 8, cycles ioctl_download is high before the first write (range 1..255).
- WR_GAP, 4, cycles ioctl_wr is low after each write pulse before the next byte is fetched (range 1..255).
- TAIL_CYC, 8, cycles ioctl_download stays high after the last write (range 1..255).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  terminate the transfer; takes effect in any non-IDLE state.
- req_index  in  8  index to present on ioctl_index.
- req_length  in  ADDR_W  number of bytes to send; 0 is legal.
- src_data  in  8  source byte.
- src_valid  in  1  source byte available.
- src_ready  out  1  byte accepted when src_valid && src_ready.
- ioctl_download  out  1  download window.
- ioctl_wr  out  1  single-cycle write strobe.
- ioctl_addr  out  ADDR_W  byte address.
- ioctl_dout  out  8  byte data.
- ioctl_index  out  8  file index.
- ioctl_wait  in  1  core back-pressure.
- busy  out  1  high when not in IDLE.
- done  out  1  one-cycle pulse when the transfer ends, normally or by abort.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-transfer drops ioctl_download on the next edge; no further ioctl_wr.
- All outputs are registered. src_ready = (state==FETCH), decoded from the state register.
- States: IDLE, SETUP, FETCH, WRITE, GAP, TAIL.
- IDLE:
  - start=1 latches req_index into ioctl_index and req_length into len_r; clears cnt.
  - Sets ioctl_download=1 and busy=1 on the next edge; moves to SETUP.
  - start while busy is ignored.
- SETUP: counts SETUP_CYC cycles. Then go to TAIL if len_r==0, else FETCH.
- FETCH:
  - src_ready=1. On accept: ioctl_dout<=src_data, ioctl_addr<=cnt; go to WRITE.
  - src_valid low stalls indefinitely; ioctl_download stays high.
- WRITE:
  - If ioctl_wait=1, hold (no strobe).
  - Else ioctl_wr<=1 for exactly one cycle, cnt<=cnt+1, go to GAP.
  - ioctl_dout and ioctl_addr are stable at least 1 cycle before the strobe and until the next FETCH accept.
- GAP:
  - ioctl_wr=0. Counts WR_GAP cycles.
  - The counter does not advance while ioctl_wait=1.
  - A wait rising in the same cycle as the strobe does not cancel that write; the byte is committed.
  - After GAP: go to TAIL if cnt==len_r, else FETCH.
- TAIL:
  - Counts TAIL_CYC cycles, then ioctl_download<=0, done<=1 for one cycle, busy<=0, return to IDLE.
  - ioctl_index and ioctl_addr hold their last values after IDLE.
- abort:
  - In SETUP/FETCH/WRITE/GAP, go to TAIL on the next edge.
  - A strobe issued in the same cycle stands; no further strobes.
  - In TAIL, abort has no additional effect.
- Widths: cnt and len_r are ADDR_W bits. Maximum length is 2^ADDR_W−1; no address wrap occurs.
- Throughput without wait or source stall: one byte per 2+WR_GAP cycles.

Decomposition:
- Shared package ioctl_pkg:
  - state enum for IDLE..TAIL.
  - IOCTL_ADDR_W=25.
  - index constants: ROM=0, TAPE=1.
  - These are also used by the sim top level and the C++ harness bindings.
- One natural sub-module: ioctl_delay_cnt, a loadable down-counter with a hold input. It is instantiated once and reloaded per phase with SETUP_CYC, WR_GAP or TAIL_CYC; hold is driven by ioctl_wait in GAP.

Test Plan:
- Basic 3-byte transfer, defaults, src_valid always 1, bytes 0xA1/0xB2/0xC3, index 0x01, start at cycle 0:
  - ioctl_download rises at cycle 1.
  - ioctl_wr pulses at cycles 11, 17, 23 with addr 0/1/2 and dout A1/B2/C3.
  - ioctl_download falls and done pulses 13 cycles after the last strobe.
  - ioctl_index=0x01 throughout.
- Length 0: ioctl_download high for SETUP_CYC+TAIL_CYC (+ transition) cycles, zero ioctl_wr pulses, single done pulse.
- ioctl_wait held high for 20 cycles while in WRITE: no strobe during wait; the strobe occurs on the first edge after wait falls; addr/dout unchanged across the stall.
- Source stall: src_valid low for 50 cycles before byte 2 → ioctl_download stays high, no spurious wr, addr sequence still 0,1,2.
- abort asserted 2 cycles after the second strobe of a 10-byte transfer → exactly 2 writes total, download drops after TAIL_CYC, done pulses once, start accepted afterward.
- reset asserted mid-GAP → all outputs 0 on the next edge; a new start then runs a clean transfer from addr 0.
